// File: rtl/ika2151_acc_pkg.sv
// rtl/ika2151_acc_pkg.sv - shared constants and float pair type for the output accumulator
package ika2151_acc_pkg;
  localparam int         ACC_WIDTH_DEF  = 20;
  localparam logic [4:0] NOISE_SLOT_DEF = 5'd31;
  localparam logic [4:0] FRAME_END_SLOT = 5'd31;
  localparam int         SAT_MAX        = 32767;
  localparam int         SAT_MIN        = -32768;
  localparam int         EXP_W          = 3;
  localparam int         MAN_W          = 10;

  typedef struct packed {
    logic [EXP_W-1:0]        fexp;
    logic signed [MAN_W-1:0] fman;
  } fp_t;
endpackage

// File: rtl/ika2151_acc_if.sv
// rtl/ika2151_acc_if.sv - slot sample inputs and latched sample outputs of the accumulator
interface ika2151_acc_if;
  logic [4:0]         i_SLOT;
  logic signed [13:0] i_OP_OUT;
  logic               i_OP_IS_CARRIER;
  logic [1:0]         i_CH_RL;
  logic               i_NE;
  logic signed [13:0] i_ACC_NOISE;
  logic signed [15:0] o_L;
  logic signed [15:0] o_R;
  logic [2:0]         o_L_EXP;
  logic signed [9:0]  o_L_MAN;
  logic [2:0]         o_R_EXP;
  logic signed [9:0]  o_R_MAN;
  logic               o_SAMPLE_VALID;

  modport master (
    output i_SLOT, i_OP_OUT, i_OP_IS_CARRIER, i_CH_RL, i_NE, i_ACC_NOISE,
    input  o_L, o_R, o_L_EXP, o_L_MAN, o_R_EXP, o_R_MAN, o_SAMPLE_VALID
  );
  modport slave (
    input  i_SLOT, i_OP_OUT, i_OP_IS_CARRIER, i_CH_RL, i_NE, i_ACC_NOISE,
    output o_L, o_R, o_L_EXP, o_L_MAN, o_R_EXP, o_R_MAN, o_SAMPLE_VALID
  );
endinterface

// File: rtl/ika2151_acc_fpconv.sv
// rtl/ika2151_acc_fpconv.sv - 16-bit signed sample to 3-bit exponent / 10-bit mantissa encoder
module ika2151_acc_fpconv
  import ika2151_acc_pkg::*;
(
  input  logic signed [15:0] i_V,
  output fp_t                o_FP
);
  logic [2:0] w_n;
  logic       w_run;
  logic [2:0] w_exp;

  always_comb begin
    w_n   = 3'd0;
    w_run = 1'b1;
    // leading sign-copy run below the sign bit, limited to six bits
    for (int i = 14; i >= 9; i--) begin
      if (w_run && (i_V[i] == i_V[15])) w_n = w_n + 3'd1;
      else                               w_run = 1'b0;
    end
    w_exp     = 3'd7 - w_n;
    o_FP.fexp = w_exp;
    o_FP.fman = MAN_W'(i_V >>> (w_exp - 3'd1));
  end
endmodule

// File: rtl/ika2151_acc.sv
// rtl/ika2151_acc.sv - per-frame L/R carrier accumulation with noise substitution, saturation and float output
module ika2151_acc
  import ika2151_acc_pkg::*;
#(
  parameter int         ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter logic [4:0] NOISE_SLOT = NOISE_SLOT_DEF
) (
  input  logic         i_EMUCLK,
  input  logic         i_MRST,
  input  logic         i_phi1_NCEN_n,
  ika2151_acc_if.slave bus
);
  localparam logic signed [ACC_WIDTH-1:0] L_MAX = ACC_WIDTH'(SAT_MAX);
  localparam logic signed [ACC_WIDTH-1:0] L_MIN = ACC_WIDTH'(SAT_MIN);

  logic signed [ACC_WIDTH-1:0] r_acc_l, r_acc_r;
  logic signed [ACC_WIDTH-1:0] w_src_ext, w_term_l, w_term_r, w_sum_l, w_sum_r;
  logic signed [13:0]          w_src;
  logic signed [15:0]          w_sat_l, w_sat_r;
  fp_t                         w_fp_l, w_fp_r;
  logic                        r_armed;
  logic                        w_tick, w_restart, w_frame_end;

  function automatic logic signed [15:0] f_sat(input logic signed [ACC_WIDTH-1:0] v);
    if (v > L_MAX)      return 16'sh7FFF;
    else if (v < L_MIN) return 16'sh8000;
    else                return v[15:0];
  endfunction

  assign w_tick      = ~i_phi1_NCEN_n;
  assign w_restart   = (bus.i_SLOT == 5'd0);
  assign w_frame_end = (bus.i_SLOT == FRAME_END_SLOT);

  assign w_src     = (bus.i_NE && (bus.i_SLOT == NOISE_SLOT)) ? bus.i_ACC_NOISE : bus.i_OP_OUT;
  assign w_src_ext = {{(ACC_WIDTH-14){w_src[13]}}, w_src};
  assign w_term_l  = (bus.i_OP_IS_CARRIER && bus.i_CH_RL[0]) ? w_src_ext : '0;
  assign w_term_r  = (bus.i_OP_IS_CARRIER && bus.i_CH_RL[1]) ? w_src_ext : '0;
  assign w_sum_l   = w_restart ? w_term_l : r_acc_l + w_term_l;
  assign w_sum_r   = w_restart ? w_term_r : r_acc_r + w_term_r;
  assign w_sat_l   = f_sat(w_sum_l);
  assign w_sat_r   = f_sat(w_sum_r);

  ika2151_acc_fpconv u_fp_l (.i_V(w_sat_l), .o_FP(w_fp_l));
  ika2151_acc_fpconv u_fp_r (.i_V(w_sat_r), .o_FP(w_fp_r));

  // r_armed blocks latching a frame end until a slot 0 has been seen since reset
  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      r_acc_l            <= '0;
      r_acc_r            <= '0;
      r_armed            <= 1'b0;
      bus.o_L            <= '0;
      bus.o_R            <= '0;
      bus.o_L_EXP        <= '0;
      bus.o_L_MAN        <= '0;
      bus.o_R_EXP        <= '0;
      bus.o_R_MAN        <= '0;
      bus.o_SAMPLE_VALID <= 1'b0;
    end else if (w_tick) begin
      r_acc_l            <= w_sum_l;
      r_acc_r            <= w_sum_r;
      bus.o_SAMPLE_VALID <= 1'b0;
      if (w_restart) r_armed <= 1'b1;
      if (w_frame_end && r_armed) begin
        bus.o_L            <= w_sat_l;
        bus.o_R            <= w_sat_r;
        bus.o_L_EXP        <= w_fp_l.fexp;
        bus.o_L_MAN        <= w_fp_l.fman;
        bus.o_R_EXP        <= w_fp_r.fexp;
        bus.o_R_MAN        <= w_fp_r.fman;
        bus.o_SAMPLE_VALID <= 1'b1;
      end
    end
  end
endmodule
